// File: rtl/amo_unit.sv
// amo_unit: RV32A atomic executor running read / combine / write-back as one locked sequence.
// Define AMO_LRSC_EN to build the LR/SC reservation; without it LR is a plain read and SC always fails.
`ifndef XLEN
`define XLEN 32
`endif

module amo_unit #(
    parameter int XLEN     = `XLEN,
    parameter int RSV_GRAN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_data,
    input  logic            i_rsv_clr,
    output logic            o_ack,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_rdata
);
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SWAP = 5'b00001;
    localparam logic [4:0] OP_LR   = 5'b00010;
    localparam logic [4:0] OP_SC   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01100;
    localparam logic [4:0] OP_MIN  = 5'b10000;
    localparam logic [4:0] OP_MAX  = 5'b10100;
    localparam logic [4:0] OP_MINU = 5'b11000;
    localparam logic [4:0] OP_MAXU = 5'b11100;

    typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, RESP} state_t;

    state_t          state, state_nxt;
    logic [4:0]      op, op_nxt;
    logic [XLEN-1:0] addr, addr_nxt, data, data_nxt, old, old_nxt, rsp, rsp_nxt;
    logic [XLEN-1:0] new_val, aligned_addr;
    logic [XLEN-1:0] rdata_nxt, mem_addr_nxt, mem_wdata_nxt;
    logic            ack_nxt, mem_req_nxt, mem_we_nxt;
    logic            start, sc_ok;

    // The ack cycle is spent in IDLE while the core still holds i_req, so it must not start a new op.
    assign start        = (state == IDLE) && i_req && !o_ack;
    assign aligned_addr = {i_addr[XLEN-1:2], 2'b00};

`ifdef AMO_LRSC_EN
    logic                   rsv_valid, rsv_valid_nxt;
    logic [XLEN-1:RSV_GRAN] rsv_gran, rsv_gran_nxt;
    logic                   unused_bits;

    assign sc_ok       = rsv_valid && (rsv_gran == i_addr[XLEN-1:RSV_GRAN]);
    assign unused_bits = ^i_addr[1:0];

    // External invalidate is applied last so it beats an LR setting the reservation.
    always_comb begin
        rsv_valid_nxt = rsv_valid;
        rsv_gran_nxt  = rsv_gran;
        if (start && i_op == OP_SC)
            rsv_valid_nxt = 1'b0;
        if (state == READ && i_mem_ack && op == OP_LR) begin
            rsv_valid_nxt = 1'b1;
            rsv_gran_nxt  = addr[XLEN-1:RSV_GRAN];
        end
        if (state == WRITE && i_mem_ack && op != OP_SC && rsv_gran == addr[XLEN-1:RSV_GRAN])
            rsv_valid_nxt = 1'b0;
        if (i_rsv_clr)
            rsv_valid_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsv_valid <= 1'b0;
            rsv_gran  <= '0;
        end else begin
            rsv_valid <= rsv_valid_nxt;
            rsv_gran  <= rsv_gran_nxt;
        end
    end
`else
    logic unused_bits;

    assign sc_ok       = 1'b0;
    assign unused_bits = ^{i_rsv_clr, i_addr[RSV_GRAN-1:0]};
`endif

    always_comb begin
        case (op)
            OP_ADD:  new_val = data + old;
            OP_SWAP: new_val = data;
            OP_XOR:  new_val = data ^ old;
            OP_OR:   new_val = data | old;
            OP_AND:  new_val = data & old;
            OP_MIN:  new_val = ($signed(data) < $signed(old)) ? data : old;
            OP_MAX:  new_val = ($signed(data) > $signed(old)) ? data : old;
            OP_MINU: new_val = (data < old) ? data : old;
            OP_MAXU: new_val = (data > old) ? data : old;
            default: new_val = data;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        op_nxt        = op;
        addr_nxt      = addr;
        data_nxt      = data;
        old_nxt       = old;
        rsp_nxt       = rsp;
        ack_nxt       = 1'b0;
        rdata_nxt     = o_rdata;
        mem_req_nxt   = o_mem_req;
        mem_we_nxt    = o_mem_we;
        mem_addr_nxt  = o_mem_addr;
        mem_wdata_nxt = o_mem_wdata;
        case (state)
            IDLE: begin
                if (start) begin
                    op_nxt   = i_op;
                    addr_nxt = aligned_addr;
                    data_nxt = i_data;
                    if (i_op == OP_SC && !sc_ok) begin
                        rsp_nxt   = {{(XLEN-1){1'b0}}, 1'b1};
                        state_nxt = RESP;
                    end else begin
                        mem_req_nxt  = 1'b1;
                        mem_we_nxt   = 1'b0;
                        mem_addr_nxt = aligned_addr;
                        state_nxt    = READ;
                    end
                end
            end
            READ: begin
                if (i_mem_ack) begin
                    old_nxt     = i_mem_rdata;
                    rsp_nxt     = (op == OP_SC) ? '0 : i_mem_rdata;
                    mem_req_nxt = 1'b0;
                    state_nxt   = (op == OP_LR) ? RESP : CALC;
                end
            end
            CALC: begin
                mem_req_nxt   = 1'b1;
                mem_we_nxt    = 1'b1;
                mem_wdata_nxt = new_val;
                state_nxt     = WRITE;
            end
            WRITE: begin
                if (i_mem_ack) begin
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    state_nxt   = RESP;
                end
            end
            RESP: begin
                ack_nxt   = 1'b1;
                rdata_nxt = rsp;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op          <= '0;
            addr        <= '0;
            data        <= '0;
            old         <= '0;
            rsp         <= '0;
            o_ack       <= 1'b0;
            o_rdata     <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            state       <= state_nxt;
            op          <= op_nxt;
            addr        <= addr_nxt;
            data        <= data_nxt;
            old         <= old_nxt;
            rsp         <= rsp_nxt;
            o_ack       <= ack_nxt;
            o_rdata     <= rdata_nxt;
            o_mem_req   <= mem_req_nxt;
            o_mem_we    <= mem_we_nxt;
            o_mem_addr  <= mem_addr_nxt;
            o_mem_wdata <= mem_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_amo_unit.sv
// tb_amo_unit: scoreboard bench for amo_unit; a word-level RV32A model predicts memory traffic,
// responses and latency, with a wait-state memory behind the DUT.
`timescale 1ns/1ps

module tb_amo_unit;
`ifdef AMO_LRSC_EN
    localparam bit LRSC_EN = 1'b1;
`else
    localparam bit LRSC_EN = 1'b0;
`endif

    localparam logic [4:0] AMOADD  = 5'b00000;
    localparam logic [4:0] AMOSWAP = 5'b00001;
    localparam logic [4:0] LR      = 5'b00010;
    localparam logic [4:0] SC      = 5'b00011;
    localparam logic [4:0] AMOXOR  = 5'b00100;
    localparam logic [4:0] AMOOR   = 5'b01000;
    localparam logic [4:0] AMOAND  = 5'b01100;
    localparam logic [4:0] AMOMIN  = 5'b10000;
    localparam logic [4:0] AMOMAX  = 5'b10100;
    localparam logic [4:0] AMOMINU = 5'b11000;
    localparam logic [4:0] AMOMAXU = 5'b11100;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } access_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] lat;
        logic [31:0] issue;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [4:0]  i_op;
    logic [31:0] i_addr, i_data;
    logic        i_rsv_clr;
    logic        o_ack, o_mem_req, o_mem_we;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    int          mem_cnt = 0;
    int          rwait, wwait;
    logic        poke_en;
    logic [31:0] poke_addr, poke_data;
    int          cyc = 0;
    bit          rsv_valid;
    logic [29:0] rsv_gran;
    access_t     q_acc [$];
    resp_t       q_rsp [$];
    int          n_vec, n_miss;
    logic [4:0]  amo_ops [0:10] = '{AMOADD, AMOSWAP, AMOXOR, AMOOR, AMOAND, AMOMIN,
                                    AMOMAX, AMOMINU, AMOMAXU, 5'b00101, 5'b11111};

    amo_unit #(.XLEN(32), .RSV_GRAN(2)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_op(i_op), .i_addr(i_addr), .i_data(i_data),
        .i_rsv_clr(i_rsv_clr), .o_ack(o_ack), .o_rdata(o_rdata), .o_mem_req(o_mem_req),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory acks combinationally once the request has waited the configured number of cycles.
    assign mem_ack   = o_mem_req && (mem_cnt >= (o_mem_we ? wwait : rwait));
    assign mem_rdata = mem[o_mem_addr[9:2]];

    always @(posedge clk) begin
        if (poke_en)
            mem[poke_addr[9:2]] <= poke_data;
        else if (o_mem_req && mem_ack && o_mem_we)
            mem[o_mem_addr[9:2]] <= o_mem_wdata;
        if (o_mem_req && !mem_ack)
            mem_cnt <= mem_cnt + 1;
        else
            mem_cnt <= 0;
    end

    // Every cycle with a live request must match the head of the expected-access queue.
    always @(negedge clk) begin
        access_t e;
        if (!rst && o_mem_req) begin
            n_vec++;
            if (q_acc.size() == 0) begin
                n_miss++;
                $display("[TB] FAIL mem_access: got we=%0b addr=%h wdata=%h, required no access",
                         o_mem_we, o_mem_addr, o_mem_wdata);
            end else begin
                e = q_acc[0];
                if (o_mem_we !== e.we || o_mem_addr !== e.addr || (e.we && o_mem_wdata !== e.wdata)) begin
                    n_miss++;
                    $display("[TB] FAIL mem_access: got we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                             o_mem_we, o_mem_addr, o_mem_wdata, e.we, e.addr, e.wdata);
                end
                if (mem_ack) void'(q_acc.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        resp_t r;
        int    lat;
        if (!rst && o_ack) begin
            n_vec++;
            if (q_rsp.size() == 0) begin
                n_miss++;
                $display("[TB] FAIL response: got o_ack rdata=%h, required no ack", o_rdata);
            end else begin
                r   = q_rsp.pop_front();
                lat = cyc - int'(r.issue);
                if (o_rdata !== r.rdata || lat != int'(r.lat)) begin
                    n_miss++;
                    $display("[TB] FAIL response: got rdata=%h latency=%0d, required rdata=%h latency=%0d",
                             o_rdata, lat, r.rdata, r.lat);
                end
            end
        end
    end

    function automatic logic [31:0] amoModel(input logic [4:0] op, input logic [31:0] rs2,
                                             input logic [31:0] m);
        int sa, sb;
        sa = rs2;
        sb = m;
        case (op)
            AMOADD:  return rs2 + m;
            AMOXOR:  return rs2 ^ m;
            AMOOR:   return rs2 | m;
            AMOAND:  return rs2 & m;
            AMOMIN:  return (sa < sb) ? rs2 : m;
            AMOMAX:  return (sa > sb) ? rs2 : m;
            AMOMINU: return (rs2 < m) ? rs2 : m;
            AMOMAXU: return (rs2 > m) ? rs2 : m;
            default: return rs2;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_vec++;
        if (actual !== required) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
        end
    endtask

    task automatic checkQuietOutputs(input string tag);
        checkOutput({tag, "_ack"}, {31'b0, o_ack}, 32'h0);
        checkOutput({tag, "_rdata"}, o_rdata, 32'h0);
        checkOutput({tag, "_mem_req"}, {31'b0, o_mem_req}, 32'h0);
        checkOutput({tag, "_mem_we"}, {31'b0, o_mem_we}, 32'h0);
        checkOutput({tag, "_mem_addr"}, o_mem_addr, 32'h0);
        checkOutput({tag, "_mem_wdata"}, o_mem_wdata, 32'h0);
    endtask

    task automatic pokeWord(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = v;
        @(negedge clk);
        poke_en = 1'b0;
        ref_mem[a[9:2]] = v;
    endtask

    task automatic checkWord(input string name, input logic [31:0] a, input logic [31:0] v);
        checkOutput(name, mem[a[9:2]], v);
    endtask

    task automatic pulseRsvClr();
        @(negedge clk);
        i_rsv_clr = 1'b1;
        @(negedge clk);
        i_rsv_clr = 1'b0;
        rsv_valid = 1'b0;
    endtask

    task automatic waitAck();
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (o_ack) seen = 1'b1;
        end
        i_req = 1'b0;
        n_vec++;
        if (!seen) begin
            n_miss++;
            $display("[TB] FAIL ack_timeout: got no o_ack in 100 cycles, required one");
        end
    endtask

    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d,
                                 input int rw, input int ww, input bit clr_held);
        access_t     acc;
        resp_t       r;
        logic [31:0] wa, old, nw;
        bit          hit;
        @(negedge clk);
        rwait = rw;
        wwait = ww;
        wa    = {a[31:2], 2'b00};
        old   = ref_mem[wa[9:2]];
        hit   = rsv_valid && (rsv_gran == wa[31:2]);
        r.issue = cyc + 1;
        acc.we = 1'b0; acc.addr = wa; acc.wdata = 32'h0;
        if (op == SC) begin
            if (LRSC_EN && hit) begin
                q_acc.push_back(acc);
                acc.we = 1'b1; acc.wdata = d;
                q_acc.push_back(acc);
                ref_mem[wa[9:2]] = d;
                r.rdata = 32'h0;
                r.lat   = 4 + rw + ww;
            end else begin
                r.rdata = 32'h1;
                r.lat   = 1;
            end
            rsv_valid = 1'b0;
        end else if (op == LR) begin
            q_acc.push_back(acc);
            r.rdata = old;
            r.lat   = 2 + rw;
            if (LRSC_EN) begin
                rsv_valid = 1'b1;
                rsv_gran  = wa[31:2];
            end
        end else begin
            nw = amoModel(op, d, old);
            q_acc.push_back(acc);
            acc.we = 1'b1; acc.wdata = nw;
            q_acc.push_back(acc);
            ref_mem[wa[9:2]] = nw;
            r.rdata = old;
            r.lat   = 4 + rw + ww;
            if (hit) rsv_valid = 1'b0;
        end
        q_rsp.push_back(r);
        i_op = op; i_addr = a; i_data = d; i_rsv_clr = clr_held; i_req = 1'b1;
        waitAck();
        i_rsv_clr = 1'b0;
        if (clr_held) rsv_valid = 1'b0;
    endtask

    // Reset lands while the write beat is stalled; the write must never reach memory.
    task automatic resetDuringWrite();
        access_t acc;
        bit      seen = 1'b0;
        applyStimulus(LR, 32'h100, 32'h0, 0, 0, 1'b0);
        @(negedge clk);
        rwait = 0;
        wwait = 3;
        acc.we = 1'b0; acc.addr = 32'h300; acc.wdata = 32'h0;
        q_acc.push_back(acc);
        acc.we = 1'b1; acc.wdata = amoModel(AMOXOR, 32'h5A5A5A5A, ref_mem[8'hC0]);
        q_acc.push_back(acc);
        i_op = AMOXOR; i_addr = 32'h300; i_data = 32'h5A5A5A5A; i_req = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (o_mem_req && o_mem_we) seen = 1'b1;
        end
        checkOutput("write_phase_reached", {31'b0, seen}, 32'h1);
        rst = 1'b1;
        #1;
        checkQuietOutputs("mid_reset");
        i_req = 1'b0;
        q_acc.delete();
        rsv_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkWord("mem_untouched_by_reset", 32'h300, ref_mem[8'hC0]);
        applyStimulus(SC, 32'h100, 32'h55, 0, 0, 1'b0);
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] base;
        int          sel;
        rst = 1'b1; i_req = 1'b0; i_op = '0; i_addr = '0; i_data = '0; i_rsv_clr = 1'b0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0; rwait = 0; wwait = 0;
        rsv_valid = 1'b0; rsv_gran = '0; n_vec = 0; n_miss = 0;
        repeat (2) @(negedge clk);
        checkQuietOutputs("reset_state");
        for (int i = 0; i < 256; i++) pokeWord(i * 4, $urandom);
        @(negedge clk);
        rst = 1'b0;

        pokeWord(32'h100, 32'd5);
        applyStimulus(AMOADD, 32'h100, 32'd3, 0, 0, 1'b0);
        checkWord("amoadd_mem", 32'h100, 32'd8);
        pokeWord(32'h104, 32'hFFFFFFFF);
        applyStimulus(AMOMIN, 32'h104, 32'd1, 0, 0, 1'b0);
        checkWord("amomin_mem", 32'h104, 32'hFFFFFFFF);
        applyStimulus(AMOMINU, 32'h104, 32'd1, 0, 0, 1'b0);
        checkWord("amominu_mem", 32'h104, 32'd1);

        pokeWord(32'h200, 32'hA);
        applyStimulus(LR, 32'h200, 32'h0, 0, 0, 1'b0);
        applyStimulus(SC, 32'h200, 32'hB, 0, 0, 1'b0);
        applyStimulus(SC, 32'h200, 32'hC, 0, 0, 1'b0);
        applyStimulus(LR, 32'h200, 32'h0, 0, 0, 1'b0);
        applyStimulus(AMOSWAP, 32'h200, 32'd7, 0, 0, 1'b0);
        applyStimulus(SC, 32'h200, 32'hD, 0, 0, 1'b0);
        checkWord("swap_then_sc_mem", 32'h200, 32'd7);
        applyStimulus(LR, 32'h200, 32'h0, 0, 0, 1'b0);
        pulseRsvClr();
        applyStimulus(SC, 32'h200, 32'hE, 0, 0, 1'b0);
        checkWord("clr_then_sc_mem", 32'h200, 32'd7);

        applyStimulus(AMOADD, 32'h300, 32'h11, 3, 3, 1'b0);

        resetDuringWrite();
        pokeWord(32'h100, 32'h0F);
        applyStimulus(AMOOR, 32'h100, 32'hF0, 0, 0, 1'b0);
        checkWord("amoor_after_reset_mem", 32'h100, 32'hFF);

        applyStimulus(LR, 32'h200, 32'h0, 1, 0, 1'b1);
        applyStimulus(SC, 32'h200, 32'h77, 0, 0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 19);
            case ($urandom_range(0, 2))
                0:       base = 32'h100;
                1:       base = 32'h200;
                default: base = 32'h304;
            endcase
            if (sel < 5)      op = LR;
            else if (sel < 9) op = SC;
            else              op = amo_ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 7) == 0) pulseRsvClr();
            applyStimulus(op, base | 32'($urandom_range(0, 3)), $urandom,
                          $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        repeat (3) @(negedge clk);
        checkOutput("acc_queue_drained", q_acc.size(), 32'h0);
        checkOutput("rsp_queue_drained", q_rsp.size(), 32'h0);
        for (int i = 0; i < 256; i++) checkOutput("final_mem", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/amo_unit.md
Name: amo_unit

Overview:
Memory-side executor for RV32A atomic requests, placed between the core LSU atomic port and the data memory bus. It accepts one AMO/LR/SC request from the core and performs the read, then the combine, then the write-back as a locked sequence. It returns the original memory word to the core. Single outstanding operation. Holds the LR/SC reservation.

Parameters:
XLEN, 32 (from `XLEN), data and address width
RSV_GRAN, 2, log2 of reservation granule in bytes; address bits [XLEN-1:RSV_GRAN] are compared

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
i_req  in  1  atomic request; held high by core until o_ack
i_op  in  5  funct5: AMOADD 00000, AMOSWAP 00001, LR 00010, SC 00011, AMOXOR 00100, AMOOR 01000, AMOAND 01100, AMOMIN 10000, AMOMAX 10100, AMOMINU 11000, AMOMAXU 11100
i_addr  in  XLEN  byte address, word aligned upstream
i_data  in  XLEN  rs2 operand
i_rsv_clr  in  1  external reservation invalidate (trap/xRET)
o_ack  out  1  one-cycle completion pulse
o_rdata  out  XLEN  result for rd, valid with o_ack
o_mem_req  out  1  memory request
o_mem_we  out  1  1 = write, 0 = read
o_mem_addr  out  XLEN  memory address, bits [1:0] forced 0
o_mem_wdata  out  XLEN  write data
i_mem_ack  in  1  memory completion; may be combinational in the same cycle as o_mem_req
i_mem_rdata  in  XLEN  read data, valid with i_mem_ack on reads

Behaviour:
- Async reset: all outputs 0, state IDLE, reservation invalid, latched op/addr/data 0. Reset mid-operation aborts the sequence; o_mem_req drops immediately; no write is issued afterwards.
- All outputs are registered.
- FSM states: IDLE, READ, CALC, WRITE, RESP.
- IDLE: if i_req=1, latch i_op, i_addr, i_data. Then:
  - SC with failing reservation -> RESP, o_rdata=1, no memory access.
  - All other ops -> READ: o_mem_req=1, o_mem_we=0.
- READ: hold o_mem_req, o_mem_we and o_mem_addr stable until i_mem_ack. On ack:
  - capture i_mem_rdata into old;
  - drop o_mem_req;
  - LR -> RESP (set reservation);
  - otherwise -> CALC.
- CALC (1 cycle): new = f(op, s1=latched i_data, s2=old):
  - SWAP: s1
  - ADD: s1+s2, modulo 2^XLEN
  - XOR/AND/OR: bitwise
  - MIN/MAX: signed compare; MINU/MAXU: unsigned compare
  - any unlisted code behaves as SWAP
  - SC: new = s1.
  - Next state WRITE with o_mem_req=1, o_mem_we=1, o_mem_wdata=new.
- WRITE: hold until i_mem_ack, then drop o_mem_req and o_mem_we -> RESP.
- RESP: o_ack=1 for exactly one cycle, then IDLE.
  - o_rdata = old for AMOs and LR; 0 for a successful SC; 1 for a failed SC.
  - o_rdata holds its value until the next o_ack.
- i_req is sampled only in IDLE. The core must drop i_req in the cycle after o_ack; if it is still high in IDLE, a new operation starts.
- Latency with zero-wait memory: o_ack asserts 4 cycles after i_req is sampled (2 for LR; 1 for a failed SC). Each memory wait cycle adds 1.
- Reservation (addr + valid bit):
  - LR sets it to addr[XLEN-1:RSV_GRAN].
  - Any SC clears it, pass or fail.
  - An AMO write to the reserved granule clears it.
  - i_rsv_clr clears it in any state.
  - If i_rsv_clr is asserted in the same cycle LR would set the reservation, the clear wins.
  - SC passes only if valid=1 and the granule matches.

Optional Feature:
AMO_LRSC_EN.
- Defined: LR/SC reservation logic and SC conditional write as described above.
- Undefined: reservation register and i_rsv_clr logic removed; the port stays and is ignored.
  - LR behaves as a plain read returning old.
  - SC always fails: no memory access, o_rdata=1, 1-cycle latency.

Test Plan:
- AMOADD addr 0x100, mem[0x100]=5, i_data=3, zero-wait memory -> read 0x100, write 8, o_rdata=5, o_ack 4 cycles after request.
- AMOMIN at a word holding 0xFFFFFFFF, i_data=1 -> writes 0xFFFFFFFF, o_rdata=0xFFFFFFFF. AMOMINU at the same word, i_data=1 -> writes 1, o_rdata=0xFFFFFFFF.
- LR 0x200 (mem=0xA), then SC 0x200 data 0xB -> LR o_rdata=0xA; SC writes 0xB, o_rdata=0. Repeat SC -> o_rdata=1, o_mem_req never asserted.
- LR 0x200, then AMOSWAP 0x200 data 7, then SC 0x200 -> SC fails, o_rdata=1, mem[0x200]=7. Repeat with i_rsv_clr pulsed between LR and SC -> SC fails.
- Memory ack delayed 3 cycles on both read and write -> o_mem_req, o_mem_we, o_mem_addr and o_mem_wdata stable throughout each wait; o_ack at cycle 10.
- rst asserted during WRITE -> all outputs 0 asynchronously, reservation invalid. After release, AMOOR 0x100 with mem=0x0F, data=0xF0 -> writes 0xFF, o_rdata=0x0F.
